inst_pipe_tracker: RTL and testbench

INST_PIPE_TRACKER -- requirements
Module: inst_pipe_tracker

---
 rtl/inst_pipe_tracker.sv | 67 ++++++
 tb/tb_inst_pipe_tracker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_pipe_tracker.sv
// inst_pipe_tracker: ID/EX/MEM/WB instruction tracker with load-use stall, jump/branch flush and event counters
module inst_pipe_tracker #(
  parameter logic [31:0] NOP     = 32'h0000_0000,
  parameter logic [5:0]  OP_LW   = 6'b100011,
  parameter logic [5:0]  OP_SW   = 6'b101011,
  parameter logic [5:0]  OP_J    = 6'b000010,
  parameter logic [5:0]  FUNC_JR = 6'b001000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_inst,
  input  logic        if_valid,
  input  logic        branch_taken,
  output logic [31:0] id_inst,
  output logic [31:0] ex_int_forward,
  output logic [31:0] mem_int_forward,
  output logic [31:0] wb_inst,
  output logic        stall,
  output logic        flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  logic [31:0] id_q, id_d, ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [5:0]  id_op;
  logic [4:0]  ex_rt;
  logic        load_use, id_is_jump;
  always_comb begin
    id_op = id_q[31:26];
    ex_rt = ex_q[20:16];
    load_use = ex_q[31:26] == OP_LW && ex_rt != 5'd0 &&
               ((id_op != OP_J && ex_rt == id_q[25:21]) ||
                ((id_op == 6'd0 || id_op == OP_SW) && ex_rt == id_q[20:16]));
    id_is_jump = id_op == OP_J || (id_op == 6'd0 && id_q[5:0] == FUNC_JR);
    stall = load_use && !branch_taken;
    flush = branch_taken || (id_is_jump && !load_use);
    id_d = branch_taken ? NOP : stall ? id_q : (id_is_jump || !if_valid) ? NOP : if_inst;
    ex_d = (branch_taken || stall) ? NOP : id_q;
    mem_d = ex_q;
    wb_d = mem_q;
    stall_cnt_d = stall_cnt_q + 16'(stall && stall_cnt_q != 16'hFFFF);
    flush_cnt_d = flush_cnt_q + 16'(flush && flush_cnt_q != 16'hFFFF);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q <= NOP;
      ex_q <= NOP;
      mem_q <= NOP;
      wb_q <= NOP;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      id_q <= id_d;
      ex_q <= ex_d;
      mem_q <= mem_d;
      wb_q <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign id_inst = id_q;
  assign ex_int_forward = ex_q;
  assign mem_int_forward = mem_q;
  assign wb_inst = wb_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_inst_pipe_tracker.sv
// tb_inst_pipe_tracker: directed vector tables plus randomized run against a behavioural pipeline model
module tb_inst_pipe_tracker;
  logic        clk = 1'b0;
  logic        rst, if_valid, branch_taken;
  logic [31:0] if_inst;
  logic [31:0] id_inst, ex_int_forward, mem_int_forward, wb_inst;
  logic        stall, flush;
  logic [15:0] stall_cnt, flush_cnt;

  inst_pipe_tracker dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .if_valid(if_valid), .branch_taken(branch_taken),
    .id_inst(id_inst), .ex_int_forward(ex_int_forward), .mem_int_forward(mem_int_forward),
    .wb_inst(wb_inst), .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI = 32'h2001_0005;  // addi $1,$0,5
  localparam logic [31:0] SUBU = 32'h00A2_1823;  // subu $3,$5,$2
  localparam logic [31:0] NOR  = 32'h0022_2027;  // nor  $4,$1,$2
  localparam logic [31:0] SLTU = 32'h0024_302B;  // sltu $6,$1,$4
  localparam logic [31:0] LW5  = 32'h8C25_0000;  // lw $5,0($1)
  localparam logic [31:0] LW31 = 32'h8C3F_0000;  // lw $31,0($1)
  localparam logic [31:0] JMP  = 32'h0800_0010;  // j 0x40
  localparam logic [31:0] JR31 = 32'h03E0_0008;  // jr $31

  int checks = 0;
  int errors = 0;

  // behavioural model: one slot per stage, counters as plain integers
  logic [31:0] m_stage [4];
  int          m_sc, m_fc;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic is_lw_hazard(input logic [31:0] d, input logic [31:0] e);
    logic [4:0] w;
    w = e[20:16];
    if (e[31:26] != 6'b100011 || w == 0) return 1'b0;
    if (d[31:26] != 6'b000010 && d[25:21] == w) return 1'b1;
    return (d[31:26] == 6'd0 || d[31:26] == 6'b101011) && d[20:16] == w;
  endfunction

  function automatic logic is_jump(input logic [31:0] d);
    return d[31:26] == 6'b000010 || (d[31:26] == 6'd0 && d[5:0] == 6'b001000);
  endfunction

  function automatic logic m_stall();
    return is_lw_hazard(m_stage[0], m_stage[1]) && !branch_taken;
  endfunction

  function automatic logic m_flush();
    return branch_taken || (is_jump(m_stage[0]) && !is_lw_hazard(m_stage[0], m_stage[1]));
  endfunction

  task automatic model_check();
    chk("id_inst", id_inst, m_stage[0]);
    chk("ex_int_forward", ex_int_forward, m_stage[1]);
    chk("mem_int_forward", mem_int_forward, m_stage[2]);
    chk("wb_inst", wb_inst, m_stage[3]);
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("flush", 32'(flush), 32'(m_flush()));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
  endtask

  task automatic drive(input logic r, input logic [31:0] inst, input logic v, input logic br, input logic mc);
    rst = r; if_inst = inst; if_valid = v; branch_taken = br;
    #1;
    if (!r && mc) model_check();
  endtask

  task automatic tick();
    logic st, fl;
    st = m_stall();
    fl = m_flush();
    @(posedge clk);
    if (rst) begin
      foreach (m_stage[i]) m_stage[i] = 32'h0;
      m_sc = 0; m_fc = 0;
    end else begin
      if (st && m_sc < 65535) m_sc++;
      if (fl && m_fc < 65535) m_fc++;
      m_stage[3] = m_stage[2];
      m_stage[2] = m_stage[1];
      if (branch_taken) begin
        m_stage[1] = 32'h0; m_stage[0] = 32'h0;
      end else if (st) m_stage[1] = 32'h0;
      else begin
        m_stage[1] = m_stage[0];
        m_stage[0] = (is_jump(m_stage[0]) || !if_valid) ? 32'h0 : if_inst;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        r;
    logic [31:0] inst;
    logic        v, br, es, ef;
    logic [31:0] eid, eex, emem, ewb;
    logic [15:0] esc, efc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [31:0] inst, logic v, logic br, logic es, logic ef,
                              logic [31:0] eid, logic [31:0] eex, logic [31:0] emem, logic [31:0] ewb,
                              logic [15:0] esc, logic [15:0] efc);
    vec_t t;
    t.r = r; t.inst = inst; t.v = v; t.br = br; t.es = es; t.ef = ef;
    t.eid = eid; t.eex = eex; t.emem = emem; t.ewb = ewb; t.esc = esc; t.efc = efc;
    return t;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: begin
        fn = ($urandom_range(0, 2) == 0) ? 6'h08 : ($urandom_range(0, 1) != 0 ? 6'h21 : 6'h23);
        return {6'd0, rs, rt, rd, 5'd0, fn};
      end
      1: return {6'b100011, rs, rt, 16'($urandom)};
      2: return {6'b101011, rs, rt, 16'($urandom)};
      3: return {6'b000010, 26'($urandom)};
      4: return {6'b001000, rs, rt, 16'($urandom)};
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    foreach (m_stage[i]) m_stage[i] = 32'h0;
    m_sc = 0; m_fc = 0;
    // straight line
    tbl.push_back(mk(1, 0,    0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, ADDI, 1, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, SUBU, 1, 0, 0, 0, ADDI, 0,    0,    0,    0, 0));
    tbl.push_back(mk(0, NOR,  1, 0, 0, 0, SUBU, ADDI, 0,    0,    0, 0));
    tbl.push_back(mk(0, SLTU, 1, 0, 0, 0, NOR,  SUBU, ADDI, 0,    0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, SLTU, NOR,  SUBU, ADDI, 0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,    SLTU, NOR,  SUBU, 0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,    0,    SLTU, NOR,  0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,    0,    0,    SLTU, 0, 0));
    // load-use
    tbl.push_back(mk(1, 0,    0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, LW5,  1, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, SUBU, 1, 0, 0, 0, LW5,  0,    0,    0,    0, 0));
    tbl.push_back(mk(0, ADDI, 1, 0, 1, 0, SUBU, LW5,  0,    0,    0, 0));
    tbl.push_back(mk(0, ADDI, 1, 0, 0, 0, SUBU, 0,    LW5,  0,    1, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, ADDI, SUBU, 0,    LW5,  1, 0));
    // j
    tbl.push_back(mk(1, 0,    0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, JMP,  1, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, ADDI, 1, 0, 0, 1, JMP,  0,    0,    0,    0, 0));
    tbl.push_back(mk(0, SUBU, 1, 0, 0, 0, 0,    JMP,  0,    0,    0, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, SUBU, 0,    JMP,  0,    0, 1));
    // lw $31 then jr $31: one stall then one flush
    tbl.push_back(mk(1, 0,    0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, LW31, 1, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, JR31, 1, 0, 0, 0, LW31, 0,    0,    0,    0, 0));
    tbl.push_back(mk(0, ADDI, 1, 0, 1, 0, JR31, LW31, 0,    0,    0, 0));
    tbl.push_back(mk(0, ADDI, 1, 0, 0, 1, JR31, 0,    LW31, 0,    1, 0));
    tbl.push_back(mk(0, NOR,  1, 0, 0, 0, 0,    JR31, 0,    LW31, 1, 1));
    // branch beats the load-use stall on a held jump
    tbl.push_back(mk(1, 0,    0, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, LW31, 1, 0, 0, 0, 0,    0,    0,    0,    0, 0));
    tbl.push_back(mk(0, JR31, 1, 0, 0, 0, LW31, 0,    0,    0,    0, 0));
    tbl.push_back(mk(0, ADDI, 1, 1, 0, 1, JR31, LW31, 0,    0,    0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,    0,    LW31, 0,    0, 1));

    @(negedge clk);
    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].inst, tbl[k].v, tbl[k].br, 1'b1);
      if (!tbl[k].r) begin
        chk($sformatf("vec%0d stall", k), 32'(stall), 32'(tbl[k].es));
        chk($sformatf("vec%0d flush", k), 32'(flush), 32'(tbl[k].ef));
        chk($sformatf("vec%0d id", k), id_inst, tbl[k].eid);
        chk($sformatf("vec%0d ex", k), ex_int_forward, tbl[k].eex);
        chk($sformatf("vec%0d mem", k), mem_int_forward, tbl[k].emem);
        chk($sformatf("vec%0d wb", k), wb_inst, tbl[k].ewb);
        chk($sformatf("vec%0d stall_cnt", k), 32'(stall_cnt), 32'(tbl[k].esc));
        chk($sformatf("vec%0d flush_cnt", k), 32'(flush_cnt), 32'(tbl[k].efc));
      end
      tick();
    end

    // randomized traffic with occasional resets
    drive(1, 0, 0, 0, 1'b0); tick();
    for (int n = 0; n < 4000; n++) begin
      drive($urandom_range(0, 99) == 0, rand_inst(), $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) == 0, 1'b1);
      tick();
    end

    // flush counter saturation
    drive(1, 0, 0, 0, 1'b0); tick();
    for (int n = 0; n < 65540; n++) begin
      drive(0, 0, 0, 1, 1'b0); tick();
    end
    drive(0, 0, 0, 0, 1'b1);
    chk("flush_cnt saturated", 32'(flush_cnt), 32'h0000_FFFF);

    // reset in the middle of a stall discards everything
    drive(0, LW5, 1, 0, 1'b1); tick();
    drive(0, SUBU, 1, 0, 1'b1); tick();
    drive(0, ADDI, 1, 0, 1'b1);
    chk("mid stall asserted", 32'(stall), 32'h1);
    drive(1, ADDI, 1, 0, 1'b0); tick();
    drive(0, NOR, 1, 0, 1'b1);
    chk("post rst id", id_inst, 32'h0);
    chk("post rst ex", ex_int_forward, 32'h0);
    chk("post rst mem", mem_int_forward, 32'h0);
    chk("post rst wb", wb_inst, 32'h0);
    chk("post rst stall", 32'(stall), 32'h0);
    chk("post rst flush", 32'(flush), 32'h0);
    chk("post rst stall_cnt", 32'(stall_cnt), 32'h0);
    chk("post rst flush_cnt", 32'(flush_cnt), 32'h0);
    tick();
    drive(0, 0, 0, 0, 1'b1);
    chk("first post rst fetch", id_inst, NOR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
